// File: rtl/rp_led_ctrl.sv
// Static-region controller for the reconfigurable LED partition: step prescaler,
// PR decouple/reload/reset handshake and frozen LED value. Define RP_TIMEOUT_EN to enable the DECOUPLED timeout.
module rp_led_ctrl #(
   parameter int PRESCALE_W  = 27,
   parameter int RST_HOLD    = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] div,
   input  logic                  pr_req,
   input  logic                  pr_done,
   output logic                  pr_ack,
   output logic                  decouple,
   output logic                  rm_en,
   output logic                  rm_reset,
   input  logic [3:0]            rm_led,
   output logic [3:0]            led,
   output logic [1:0]            state,
   output logic                  pr_err
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_DRAIN     = 2'd1,
      ST_DECOUPLED = 2'd2,
      ST_RESTORE   = 2'd3
   } state_t;

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
   localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);
   localparam logic [HOLD_W-1:0]     HOLD_ZERO  = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0]     HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(RST_HOLD - 1);

   state_t                  state_r;
   logic [PRESCALE_W-1:0]   presc_r;
   logic [HOLD_W-1:0]       hold_r;
   logic                    drain_r;
   logic [3:0]              freeze_r;
   logic                    pr_ack_r;
   logic                    decouple_r;
   logic                    rm_en_r;
   logic                    rm_reset_r;
   logic [3:0]              led_r;
   logic                    tick_s;
   logic                    timeout_s;

   // A step is due once the count reaches div; >= lets a lowered div wrap at once.
   assign tick_s = run && (presc_r >= div);

`ifdef RP_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] to_r;
   logic            pr_err_r;

   assign timeout_s = (to_r == TO_LAST);

   // Cycles spent in DECOUPLED; the sticky error marks a reload that never finished.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_r     <= TO_ZERO;
         pr_err_r <= 1'b0;
      end else if (state_r != ST_DECOUPLED) begin
         to_r     <= TO_ZERO;
      end else if (timeout_s) begin
         to_r     <= TO_ZERO;
         if (pr_req && !pr_done) begin
            pr_err_r <= 1'b1;
         end else begin
            pr_err_r <= pr_err_r;
         end
      end else begin
         to_r     <= to_r + TO_ONE;
      end
   end

   assign pr_err = pr_err_r;
`else
   logic unused_timeout_s;

   // The timeout limit has no effect when the DECOUPLED watchdog is left out.
   assign unused_timeout_s = (TIMEOUT_CYC > 32'sd0);
   assign timeout_s        = 1'b0;
   assign pr_err           = 1'b0;
`endif

   // Handshake FSM with all partition-facing outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_RESTORE;
         presc_r    <= PRESC_ZERO;
         hold_r     <= HOLD_ZERO;
         drain_r    <= 1'b0;
         freeze_r   <= 4'b0000;
         pr_ack_r   <= 1'b0;
         decouple_r <= 1'b1;
         rm_en_r    <= 1'b0;
         rm_reset_r <= 1'b1;
         led_r      <= 4'b0000;
      end else begin
         case (state_r)
            ST_RUN: begin
               decouple_r <= 1'b0;
               rm_reset_r <= 1'b0;
               pr_ack_r   <= 1'b0;
               led_r      <= rm_led;
               if (pr_req) begin
                  state_r <= ST_DRAIN;
                  drain_r <= 1'b0;
                  rm_en_r <= 1'b0;
               end else if (tick_s) begin
                  presc_r <= PRESC_ZERO;
                  rm_en_r <= 1'b1;
               end else if (run) begin
                  presc_r <= presc_r + PRESC_ONE;
                  rm_en_r <= 1'b0;
               end else begin
                  rm_en_r <= 1'b0;
               end
            end

            ST_DRAIN: begin
               rm_en_r <= 1'b0;
               led_r   <= rm_led;
               if (drain_r) begin
                  freeze_r   <= rm_led;
                  state_r    <= ST_DECOUPLED;
                  pr_ack_r   <= 1'b1;
                  decouple_r <= 1'b1;
                  drain_r    <= 1'b0;
               end else begin
                  drain_r    <= 1'b1;
               end
            end

            ST_DECOUPLED: begin
               rm_en_r <= 1'b0;
               led_r   <= freeze_r;
               // Done, abort and timeout all leave through the same reset sequence.
               if (pr_done || !pr_req || timeout_s) begin
                  state_r    <= ST_RESTORE;
                  pr_ack_r   <= 1'b0;
                  rm_reset_r <= 1'b1;
                  hold_r     <= HOLD_ZERO;
               end else begin
                  pr_ack_r   <= 1'b1;
               end
            end

            ST_RESTORE: begin
               rm_en_r <= 1'b0;
               led_r   <= freeze_r;
               if (hold_r == HOLD_LAST) begin
                  state_r    <= ST_RUN;
                  rm_reset_r <= 1'b0;
                  decouple_r <= 1'b0;
                  presc_r    <= PRESC_ZERO;
                  hold_r     <= HOLD_ZERO;
               end else begin
                  hold_r     <= hold_r + HOLD_ONE;
               end
            end

            default: begin
               state_r    <= ST_RESTORE;
               hold_r     <= HOLD_ZERO;
               pr_ack_r   <= 1'b0;
               decouple_r <= 1'b1;
               rm_en_r    <= 1'b0;
               rm_reset_r <= 1'b1;
            end
         endcase
      end
   end

   assign pr_ack   = pr_ack_r;
   assign decouple = decouple_r;
   assign rm_en    = rm_en_r;
   assign rm_reset = rm_reset_r;
   assign led      = led_r;
   assign state    = state_r;

endmodule

// File: tb/tb_rp_led_ctrl.sv
// Bench for rp_led_ctrl: directed handshake scenarios plus random traffic, all
// compared every cycle against a phase/duration model of the controller.
module tb_rp_led_ctrl;

   localparam int PW = 27;
   localparam int RH = 16;
   localparam int TO = 50;

   logic          clk = 1'b0;
   logic          reset, run, pr_req, pr_done;
   logic [PW-1:0] div;
   logic [3:0]    rm_led;
   logic          pr_ack, decouple, rm_en, rm_reset, pr_err;
   logic [3:0]    led;
   logic [1:0]    state;

   int n_chk = 0;
   int n_err = 0;
   bit rand_led = 1'b0;

   rp_led_ctrl #(.PRESCALE_W(PW), .RST_HOLD(RH), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .run(run), .div(div),
      .pr_req(pr_req), .pr_done(pr_done), .pr_ack(pr_ack),
      .decouple(decouple), .rm_en(rm_en), .rm_reset(rm_reset),
      .rm_led(rm_led), .led(led), .state(state), .pr_err(pr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: phase (0 run,1 drain,2 decoupled,3 restore) plus time spent in it.
   int         m_ph = 3;
   int         m_t = 0;
   int         m_cnt = 0;
   logic [3:0] m_led = 4'd0;
   logic [3:0] m_frz = 4'd0;
   bit         m_en = 1'b0;
   bit         m_err = 1'b0;
   bit         m_valid = 1'b0;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_ph = 3; m_t = 0; m_cnt = 0; m_led = 4'd0; m_frz = 4'd0;
         m_en = 1'b0; m_err = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
         m_en = 1'b0;
         if (m_ph == 0) begin
            m_led = rm_led;
            if (pr_req) begin
               m_ph = 1; m_t = 0;
            end else if (run) begin
               if (m_cnt >= int'(div)) begin
                  m_cnt = 0; m_en = 1'b1;
               end else begin
                  m_cnt = m_cnt + 1;
               end
            end
         end else if (m_ph == 1) begin
            m_led = rm_led;
            m_t = m_t + 1;
            if (m_t == 2) begin
               m_frz = rm_led; m_ph = 2; m_t = 0;
            end
         end else if (m_ph == 2) begin
            m_led = m_frz;
            m_t = m_t + 1;
            if (pr_done || !pr_req) begin
               m_ph = 3; m_t = 0;
`ifdef RP_TIMEOUT_EN
            end else if (m_t == TO) begin
               m_err = 1'b1; m_ph = 3; m_t = 0;
`endif
            end
         end else begin
            m_led = m_frz;
            m_t = m_t + 1;
            if (m_t == RH) begin
               m_ph = 0; m_t = 0; m_cnt = 0;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("state",    int'(state),    m_ph);
         chk("pr_ack",   int'(pr_ack),   int'(m_ph == 2));
         chk("decouple", int'(decouple), int'(m_ph >= 2));
         chk("rm_reset", int'(rm_reset), int'(m_ph == 3));
         chk("rm_en",    int'(rm_en),    int'(m_en));
         chk("led",      int'(led),      int'(m_led));
         chk("pr_err",   int'(pr_err),   int'(m_err));
      end
   end

   task automatic step();
      @(negedge clk);
      if (rand_led) rm_led = 4'($urandom);
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return rm_en;
         1:       return pr_ack;
         2:       return !decouple;
         3:       return state == 2'd0;
         4:       return pr_err;
         default: return !rm_reset;
      endcase
   endfunction

   task automatic wait_for(input int which, output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (!cond(which) && k < 200);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      reset = 1'b1; run = 1'b0; div = PW'(3); pr_req = 1'b0; pr_done = 1'b0; rm_led = 4'd0;
      repeat (3) step();
      chk("rst_state", int'(state), 3);
      chk("rst_rm_reset", int'(rm_reset), 1);
      chk("rst_decouple", int'(decouple), 1);
      chk("rst_led", int'(led), 0);
      chk("rst_pr_ack", int'(pr_ack), 0);
      chk("rst_rm_en", int'(rm_en), 0);

      // Power-up reset hold, then div=3 step rhythm.
      reset = 1'b0; run = 1'b1; rand_led = 1'b1;
      wait_for(5, k); chk("rm_reset_hold", k, 16);
      wait_for(0, k); chk("first_step_gap", k, 4);
      wait_for(0, k); chk("step_gap_div3", k, 4);

      // div 9 -> 2 while the prescaler sits at 7.
      div = PW'(9);
      repeat (7) step();
      div = PW'(2);
      step(); chk("div_drop_step", int'(rm_en), 1);
      wait_for(0, k); chk("step_gap_div2", k, 3);

      // Request in the cycle a step is due; LEDs freeze at 4'b0100.
      rand_led = 1'b0; rm_led = 4'b0100;
      repeat (2) step();
      pr_req = 1'b1;
      step(); chk("tick_suppressed", int'(rm_en), 0);
      k = 1;
      while (!pr_ack && k < 200) begin step(); k++; end
      chk("req_ack_latency", k, 3);
      rand_led = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); chk("led_frozen", int'(led), 4);
      end

      // Bitstream done: ack drops, 16-cycle module reset, then decouple releases.
      pr_done = 1'b1;
      step();
      pr_done = 1'b0; pr_req = 1'b0;
      chk("done_ack_drop", int'(pr_ack), 0);
      chk("done_rm_reset", int'(rm_reset), 1);
      k = 1;
      while (decouple && k < 200) begin step(); k++; end
      chk("done_decouple_lat", k, 17);
      wait_for(0, k); chk("post_restore_step", k, 3);

      // Abort: request withdrawn while decoupled.
      pr_req = 1'b1;
      wait_for(1, k); chk("abort_ack_latency", k, 3);
      repeat (4) step();
      pr_req = 1'b0;
      step();
      chk("abort_state", int'(state), 3);
      chk("abort_pr_err", int'(pr_err), 0);
      wait_for(3, k); chk("abort_restore_len", k, 16);

      // Reload never completes.
      pr_req = 1'b1;
      wait_for(1, k); chk("to_ack_latency", k, 3);
`ifdef RP_TIMEOUT_EN
      wait_for(4, k); chk("timeout_cycles", k, 50);
      chk("timeout_state", int'(state), 3);
      wait_for(3, k); chk("timeout_restore_len", k, 16);
      step();
      chk("timeout_redrain", int'(state), 1);
      chk("timeout_err_sticky", int'(pr_err), 1);
`else
      repeat (60) step();
      chk("no_timeout_state", int'(state), 2);
      chk("no_timeout_err", int'(pr_err), 0);
`endif
      pr_req = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_clears_err", int'(pr_err), 0);

      // Random traffic checked by the model.
      for (int i = 0; i < 4000; i++) begin
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) div = PW'($urandom_range(0, 5));
         if ($urandom_range(0, 39) == 0) pr_req = ~pr_req;
         pr_done = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0; pr_done = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rp_led_ctrl.md
Name: rp_led_ctrl

Overview:
- Controller for the reconfigurable LED partition (shift-pattern LED modules swapped by partial reconfiguration).
- Generates the prescaled step enable for the loaded module and runs the decouple/reconfigure/restore handshake with the PR controller.
- Holds the module in reset after a new bitstream lands, and supplies the board LEDs with a safe frozen value while the partition is decoupled.
- Sits in the static region between the PS-side PR controller, the reconfigurable partition and the LED pins.

Parameters:
- PRESCALE_W, 27, width of the prescaler counter and of the div input.
- RST_HOLD, 16, number of cycles rm_reset is held high in RESTORE (must be at least 1).
- TIMEOUT_CYC, 1000000, cycle limit in DECOUPLED; used only with RP_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- run  input  1  level; 1 = prescaler advances and steps are issued
- div  input  PRESCALE_W  step period minus one (0 = step every cycle)
- pr_req  input  1  level request from PR controller to reconfigure the partition
- pr_done  input  1  one-cycle pulse: bitstream load complete
- pr_ack  output  1  partition decoupled; safe to load bitstream
- decouple  output  1  isolates partition outputs
- rm_en  output  1  one-cycle step enable to the reconfigurable module
- rm_reset  output  1  reset to the reconfigurable module
- rm_led  input  4  LED value from the reconfigurable module
- led  output  4  board LEDs
- state  output  2  FSM state: RUN=0, DRAIN=1, DECOUPLED=2, RESTORE=3
- pr_err  output  1  sticky timeout flag (tied 0 without RP_TIMEOUT_EN)

Behaviour:
- All outputs are registered. Reset forces the following values:
  - state=RESTORE, rm_reset=1, decouple=1
  - pr_ack=0, rm_en=0, led=4'b0000, pr_err=0
  - prescaler=0, hold counter=0
- Reset mid-operation aborts any handshake and follows the same sequence, so the module is always re-reset after power-up.
- RUN:
  - decouple=0, rm_reset=0, led=rm_led (one-cycle registered path).
  - If run=1: prescaler increments. When prescaler >= div, it clears to 0 and rm_en=1 for exactly one cycle. The >= compare means a div decrease mid-count wraps without a missed step.
  - If run=0: prescaler holds and rm_en=0.
  - pr_req=1 moves to DRAIN. A tick due in that same cycle is suppressed (rm_en=0) and the prescaler holds.
- DRAIN:
  - Lasts exactly 2 cycles, with rm_en=0, so the last step settles in the module.
  - On the final cycle, rm_led is captured into a freeze register, then the FSM moves to DECOUPLED.
  - If pr_req drops during DRAIN, the drain still completes, then the FSM takes the abort path below.
- DECOUPLED:
  - decouple=1, pr_ack=1, led=freeze register.
  - pr_done=1 moves to RESTORE; pr_ack drops in the same transition.
  - If pr_req=0 and pr_done=0 (abort), the FSM also moves to RESTORE.
  - If pr_done and pr_req deassertion coincide, they are treated as done.
  - pr_done outside DECOUPLED is ignored.
- RESTORE:
  - decouple=1, rm_reset=1, led=freeze register (0 after reset), rm_en=0.
  - Hold counter runs RST_HOLD cycles. Then: rm_reset=0, decouple=0, prescaler cleared, enter RUN.
  - If pr_req is still high on exit, RUN immediately re-enters DRAIN next cycle with no rm_en issued.
- Total latency pr_req↑ → pr_ack↑: 3 cycles (1 RUN + 2 DRAIN).
- Total latency pr_done → decouple↓: RST_HOLD+1 cycles.

Optional Feature:
- Macro: RP_TIMEOUT_EN.
- Defined:
  - A counter runs while in DECOUPLED.
  - Reaching TIMEOUT_CYC cycles without pr_done sets pr_err=1 (sticky until reset) and forces a move to RESTORE, exactly as an abort.
  - The counter clears on entry to DECOUPLED.
- Undefined:
  - No counter; DECOUPLED waits indefinitely.
  - pr_err is constant 0.

Test Plan:
- Reset released, run=1, div=3, rm_led driven → rm_reset high for 16 cycles after reset, then rm_en pulses every 4th cycle and led tracks rm_led one cycle later.
- div changed from 9 to 2 while prescaler=7 → rm_en on the next cycle, then every 3 cycles.
- In RUN with rm_led=4'b0100, pr_req↑ in the cycle a tick is due → no rm_en; pr_ack↑ 3 cycles later; led holds 4'b0100 while rm_led toggles X/garbage.
- In DECOUPLED, pulse pr_done → pr_ack↓ next cycle; rm_reset high 16 cycles; decouple↓ at cycle 17; first rm_en div+1 cycles after entering RUN.
- In DECOUPLED, drop pr_req without pr_done → RESTORE sequence runs; pr_err stays 0.
- With RP_TIMEOUT_EN and TIMEOUT_CYC=50, hold pr_req=1 with no pr_done → pr_err=1 at cycle 50 in DECOUPLED, then RESTORE. Once back in RUN (pr_req still 1), re-enters DRAIN; pr_err stays 1 until reset.
